alu_sweep_driver: RTL and testbench

//  Sequential stimulus/capture engine that drives the combinational ALU across a range of op codes.

---
 rtl/alu_sweep_driver_pkg.sv | 34 +++
 rtl/alu_sweep_driver_if.sv | 26 ++
 rtl/alu_sweep_driver_result_buf.sv | 31 +++
 rtl/alu_sweep_driver.sv | 179 +++++++++++++++++
 tb/tb_alu_sweep_driver.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_sweep_driver_pkg.sv
// Shared definitions for the ALU sweep driver slice.
//  - state_e      : sweep FSM state encoding (also shown on ledr outside DONE)
//  - FLAG_*       : bit positions of the ALU flags inside the captured flag nibble
//  - ALU_OP_*     : op codes of the attached ALU that board-level code refers to
//  - board widths : LED / switch field widths
package alu_sweep_driver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  // Flag nibble layout: {neg, parity, overflow, carry}
  localparam int NUM_FLAGS     = 4;
  localparam int FLAG_CARRY    = 0;
  localparam int FLAG_OVERFLOW = 1;
  localparam int FLAG_PARITY   = 2;
  localparam int FLAG_NEG      = 3;

  // ALU op codes referenced by board bring-up
  localparam logic [4:0] ALU_OP_ADD = 5'h10;
  localparam logic [4:0] ALU_OP_SUB = 5'h11;

  // Board I/O widths
  localparam int SW_W       = 10;
  localparam int SW_FIELD_W = 5;
  localparam int LEDR_W     = 10;
  localparam int LEDG_W     = 8;

endpackage

// File: rtl/alu_sweep_driver_if.sv
// Bus between the sweep driver and the combinational ALU.
//  master (sweep driver): drives op_a/op_b/op_code, receives alu_out and flags
//  slave  (ALU)         : receives operands/op code, drives alu_out and flags
interface alu_sweep_driver_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 5
);
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [OP_W-1:0]   op_code;
  logic [DATA_W-1:0] alu_out;
  logic              flag_carry;
  logic              flag_overflow;
  logic              flag_parity;
  logic              flag_neg;

  modport master (
    output op_a, op_b, op_code,
    input  alu_out, flag_carry, flag_overflow, flag_parity, flag_neg
  );

  modport slave (
    input  op_a, op_b, op_code,
    output alu_out, flag_carry, flag_overflow, flag_parity, flag_neg
  );
endinterface

// File: rtl/alu_sweep_driver_result_buf.sv
// alu_result_buf: result capture RAM, one write port and one synchronous read port.
//  clk    : clock
//  we     : write enable
//  waddr  : write address (op code of the captured result)
//  wdata  : {flags, alu_out}
//  raddr  : read address
//  rdata  : registered read data, valid the cycle after raddr is presented
// Contents are deliberately not reset so the array maps onto block RAM.
module alu_result_buf #(
  parameter int ADDR_W = 5,
  parameter int WORD_W = 36
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [2**ADDR_W];
  logic [WORD_W-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_reg <= mem[raddr];
  end

  assign rdata = rdata_reg;
endmodule

// File: rtl/alu_sweep_driver.sv
// alu_sweep_driver: steps the ALU op code over [OP_FIRST, OP_LAST] with operands
// latched from the board switches, captures every {flags, result} into a buffer
// and folds all results into a rotate-XOR signature.
// Ports:
//  clk, reset   : clock, synchronous active-high reset
//  sw           : sw[4:0] operand A, sw[9:5] operand B (zero-extended, latched in LOAD)
//  start        : level, sampled in IDLE/DONE to launch a sweep
//  rd_sel       : buffer entry shown on the LEDs while in DONE
//  alu          : master side of the ALU bus (operands, op code, result, flags)
//  ledr/ledg    : DONE: result[17:8]/[7:0] of the rd_sel entry; else status / zero
//  flags_o      : DONE: {neg,parity,overflow,carry} of the rd_sel entry; else 0
//  signature    : running signature, final when done=1
//  busy / done  : sweep in progress / sweep finished
module alu_sweep_driver
  import alu_sweep_driver_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int OP_W     = 5,
  parameter int SETTLE   = 2,
  parameter int OP_FIRST = 0,
  parameter int OP_LAST  = 31
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SW_W-1:0]    sw,
  input  logic               start,
  input  logic [OP_W-1:0]    rd_sel,
  alu_sweep_driver_if.master alu,
  output logic [LEDR_W-1:0]  ledr,
  output logic [LEDG_W-1:0]  ledg,
  output logic [NUM_FLAGS-1:0] flags_o,
  output logic [DATA_W-1:0]  signature,
  output logic               busy,
  output logic               done
);

  localparam int BUF_W = DATA_W + NUM_FLAGS;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [OP_W-1:0]  OP_FIRST_C = OP_W'(OP_FIRST);
  localparam logic [OP_W-1:0]  OP_LAST_C  = OP_W'(OP_LAST);
  localparam logic [CNT_W-1:0] CNT_LOAD_C = CNT_W'(SETTLE - 1);

  state_e              state_reg, state_next;
  logic [DATA_W-1:0]   op_a_reg, op_b_reg, sig_reg;
  logic [OP_W-1:0]     op_code_reg;
  logic [CNT_W-1:0]    cnt_reg;

  logic [DATA_W-1:0]   sw_a_ext, sw_b_ext;
  logic [NUM_FLAGS-1:0] flags_in;
  logic [BUF_W-1:0]    rd_data;
  logic                buf_we;
  logic                buf_unused;

  // Zero-extend the two 5-bit switch fields to operand width
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_ext
      if (gi < SW_FIELD_W) begin : g_sw
        assign sw_a_ext[gi] = sw[gi];
        assign sw_b_ext[gi] = sw[gi + SW_FIELD_W];
      end else begin : g_zero
        assign sw_a_ext[gi] = 1'b0;
        assign sw_b_ext[gi] = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    flags_in                = '0;
    flags_in[FLAG_CARRY]    = alu.flag_carry;
    flags_in[FLAG_OVERFLOW] = alu.flag_overflow;
    flags_in[FLAG_PARITY]   = alu.flag_parity;
    flags_in[FLAG_NEG]      = alu.flag_neg;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (start) state_next = ST_LOAD;
      ST_LOAD:    state_next = ST_ISSUE;
      ST_ISSUE:   state_next = ST_SETTLE;
      ST_SETTLE:  if (cnt_reg == '0) state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = (op_code_reg == OP_LAST_C) ? ST_DONE : ST_ISSUE;
      ST_DONE:    if (start) state_next = ST_LOAD;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Datapath: operands, op code, settle counter and signature
  always_ff @(posedge clk) begin
    if (reset) begin
      op_a_reg    <= '0;
      op_b_reg    <= '0;
      op_code_reg <= OP_FIRST_C;
      sig_reg     <= '0;
      cnt_reg     <= '0;
    end else begin
      case (state_reg)
        ST_LOAD: begin
          op_a_reg    <= sw_a_ext;
          op_b_reg    <= sw_b_ext;
          op_code_reg <= OP_FIRST_C;
          sig_reg     <= '0;
        end
        ST_ISSUE: begin
          cnt_reg <= CNT_LOAD_C;
        end
        ST_SETTLE: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        ST_CAPTURE: begin
          sig_reg <= {sig_reg[DATA_W-2:0], sig_reg[DATA_W-1]} ^ alu.alu_out;
          // Hold at OP_LAST so the code never wraps past the top of the range
          if (op_code_reg != OP_LAST_C) begin
            op_code_reg <= op_code_reg + OP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign buf_we = (state_reg == ST_CAPTURE);

  alu_result_buf #(
    .ADDR_W (OP_W),
    .WORD_W (BUF_W)
  ) u_result_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (op_code_reg),
    .wdata ({flags_in, alu.alu_out}),
    .raddr (rd_sel),
    .rdata (rd_data)
  );

  // Result bits above the LED window are only visible through the signature
  assign buf_unused = ^rd_data[DATA_W-1:LEDR_W+LEDG_W];

  // Outputs: status flags and LED mux
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    ledr    = '0;
    ledg    = '0;
    flags_o = '0;
    case (state_reg)
      ST_LOAD, ST_ISSUE, ST_SETTLE, ST_CAPTURE: busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: ;
    endcase
    if (state_reg == ST_DONE) begin
      ledr    = rd_data[LEDR_W+LEDG_W-1:LEDG_W];
      ledg    = rd_data[LEDG_W-1:0];
      flags_o = rd_data[BUF_W-1:DATA_W];
    end else begin
      // Status view {state, 3'b0, op_code} clipped to the 10 red LEDs
      ledr = LEDR_W'({state_reg, 3'b000, op_code_reg});
    end
  end

  assign alu.op_a    = op_a_reg;
  assign alu.op_b    = op_b_reg;
  assign alu.op_code = op_code_reg;
  assign signature   = sig_reg;

endmodule

// File: tb/tb_alu_sweep_driver.sv
module tb_alu_sweep_driver;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  sw = '0;
  logic        start = 1'b0;
  logic [4:0]  rd_sel = '0;
  logic [9:0]  ledr;
  logic [7:0]  ledg;
  logic [3:0]  flags_o;
  logic [31:0] signature;
  logic        busy, done;

  logic [9:0]  sw2 = '0;
  logic        start2 = 1'b0;
  logic [4:0]  rd_sel2 = '0;
  logic [9:0]  ledr2;
  logic [7:0]  ledg2;
  logic [3:0]  flags2;
  logic [31:0] signature2;
  logic        busy2, done2;

  int          alu_mode = 0;
  logic [31:0] salt = '0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  // Reference ALU behaviour used by both the attached model and the expectations
  function automatic logic [31:0] alu_fn(input int mode, input logic [31:0] a,
                                         input logic [31:0] b, input logic [4:0] op,
                                         input logic [31:0] s);
    logic [31:0] r;
    case (mode)
      0:       r = (op == 5'd16) ? a + b : (a * ({27'b0, op} + 32'd1)) ^ (b << op[2:0]);
      1:       r = {27'b0, op};
      default: r = (a * 32'h9E3779B1) ^ (b * 32'h85EBCA6B) ^ ({27'b0, op} * 32'hC2B2AE35) ^ s;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] exp_result(input int mode, input logic [9:0] swv,
                                             input int op, input logic [31:0] s);
    return alu_fn(mode, {27'b0, swv[4:0]}, {27'b0, swv[9:5]}, op[4:0], s);
  endfunction

  function automatic logic [31:0] exp_signature(input int mode, input logic [9:0] swv,
                                                input int first, input int last,
                                                input logic [31:0] s);
    logic [31:0] sig = 32'd0;
    for (int op = first; op <= last; op++) begin
      sig = ((sig << 1) | (sig >> 31)) ^ exp_result(mode, swv, op, s);
    end
    return sig;
  endfunction

  function automatic logic [21:0] led_word(input logic [31:0] r);
    return {r[31:28], r[17:8], r[7:0]};
  endfunction

  alu_sweep_driver_if #(.DATA_W(32), .OP_W(5)) alu_bus ();
  alu_sweep_driver_if #(.DATA_W(32), .OP_W(5)) alu_bus2 ();

  always_comb alu_bus.alu_out = alu_fn(alu_mode, alu_bus.op_a, alu_bus.op_b, alu_bus.op_code, salt);
  assign alu_bus.flag_carry    = alu_bus.alu_out[28];
  assign alu_bus.flag_overflow = alu_bus.alu_out[29];
  assign alu_bus.flag_parity   = alu_bus.alu_out[30];
  assign alu_bus.flag_neg      = alu_bus.alu_out[31];

  always_comb alu_bus2.alu_out = alu_fn(0, alu_bus2.op_a, alu_bus2.op_b, alu_bus2.op_code, 32'd0);
  assign alu_bus2.flag_carry    = alu_bus2.alu_out[28];
  assign alu_bus2.flag_overflow = alu_bus2.alu_out[29];
  assign alu_bus2.flag_parity   = alu_bus2.alu_out[30];
  assign alu_bus2.flag_neg      = alu_bus2.alu_out[31];

  alu_sweep_driver dut (
    .clk(clk), .reset(reset), .sw(sw), .start(start), .rd_sel(rd_sel),
    .alu(alu_bus), .ledr(ledr), .ledg(ledg), .flags_o(flags_o),
    .signature(signature), .busy(busy), .done(done)
  );

  alu_sweep_driver #(.SETTLE(1), .OP_FIRST(3), .OP_LAST(3)) dut2 (
    .clk(clk), .reset(reset), .sw(sw2), .start(start2), .rd_sel(rd_sel2),
    .alu(alu_bus2), .ledr(ledr2), .ledg(ledg2), .flags_o(flags2),
    .signature(signature2), .busy(busy2), .done(done2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int max_cycles, output int n);
    n = 0;
    while (done !== 1'b1 && n < max_cycles) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    repeat (10) tick();
    checks += 7;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
    if (alu_bus.op_code !== 5'd0) begin failures++; $display("FAIL reset_opcode got=%0d exp=0", alu_bus.op_code); end
    if (signature !== 32'd0) begin failures++; $display("FAIL reset_sig got=%h exp=0", signature); end
    if (ledg !== 8'h00) begin failures++; $display("FAIL reset_ledg got=%h exp=00", ledg); end
    if (ledr !== 10'h000) begin failures++; $display("FAIL reset_ledr got=%h exp=000", ledr); end
    if (flags_o !== 4'h0) begin failures++; $display("FAIL reset_flags got=%h exp=0", flags_o); end
    $display("reset: busy=%0b done=%0b op_code=%0d sig=%h", busy, done, alu_bus.op_code, signature);
  endtask

  task automatic test_add_sweep();
    int n;
    logic [31:0] es;
    alu_mode = 0;
    sw = 10'b00011_00101;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1000, n);
    es = exp_signature(0, sw, 0, 31, salt);
    checks += 2;
    if (n !== 129) begin failures++; $display("FAIL add_latency got=%0d exp=129", n); end
    if (signature !== es) begin failures++; $display("FAIL add_sig got=%h exp=%h", signature, es); end
    rd_sel = 5'b10000;
    tick();
    checks += 3;
    if (ledg !== 8'h08) begin failures++; $display("FAIL add_ledg got=%h exp=08", ledg); end
    if (ledr !== 10'h000) begin failures++; $display("FAIL add_ledr got=%h exp=000", ledr); end
    if (flags_o !== 4'h0) begin failures++; $display("FAIL add_flags got=%h exp=0", flags_o); end
    $display("add sweep: cycles=%0d ledg=%h ledr=%h sig=%h", n, ledg, ledr, signature);
  endtask

  task automatic test_sw_change();
    int n;
    int sel;
    logic [9:0]  sw0;
    logic [31:0] es;
    alu_mode = 2;
    salt = $urandom;
    sw0 = 10'($urandom);
    sw = sw0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    sw = ~sw0;
    repeat (3) tick();
    checks += 2;
    if (alu_bus.op_a !== {27'b0, sw0[4:0]}) begin failures++; $display("FAIL swchg_op_a got=%h exp=%h", alu_bus.op_a, {27'b0, sw0[4:0]}); end
    if (alu_bus.op_b !== {27'b0, sw0[9:5]}) begin failures++; $display("FAIL swchg_op_b got=%h exp=%h", alu_bus.op_b, {27'b0, sw0[9:5]}); end
    wait_done(1000, n);
    es = exp_signature(2, sw0, 0, 31, salt);
    checks += 2;
    if (n !== 129 - 23) begin failures++; $display("FAIL swchg_latency got=%0d exp=%0d", n, 129 - 23); end
    if (signature !== es) begin failures++; $display("FAIL swchg_sig got=%h exp=%h", signature, es); end
    for (int k = 0; k < 6; k++) begin
      sel = (k == 0) ? 0 : (k == 1) ? 31 : int'($urandom_range(0, 31));
      rd_sel = 5'(sel);
      tick();
      checks++;
      if ({flags_o, ledr, ledg} !== led_word(exp_result(2, sw0, sel, salt))) begin
        failures++;
        $display("FAIL swchg_entry%0d got=%h exp=%h", sel, {flags_o, ledr, ledg}, led_word(exp_result(2, sw0, sel, salt)));
      end
    end
    $display("sw change: sw0=%h sig=%h", sw0, signature);
  endtask

  task automatic test_opcode_sig();
    int n;
    logic [31:0] gold = 32'd0;
    for (int op = 0; op < 32; op++) begin
      gold = ((gold << 1) | (gold >> 31)) ^ op;
    end
    alu_mode = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1000, n);
    checks += 2;
    if (n !== 129) begin failures++; $display("FAIL opsig_latency got=%0d exp=129", n); end
    if (signature !== gold) begin failures++; $display("FAIL opsig_sig got=%h exp=%h", signature, gold); end
    $display("opcode signature: sig=%h", signature);
  endtask

  task automatic test_reset_mid();
    bit seen_done = 1'b0;
    alu_mode = 0;
    sw = 10'($urandom);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (40) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks += 5;
    if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%0b exp=0", busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%0b exp=0", done); end
    if (signature !== 32'd0) begin failures++; $display("FAIL rstmid_sig got=%h exp=0", signature); end
    if (alu_bus.op_code !== 5'd0) begin failures++; $display("FAIL rstmid_opcode got=%0d exp=0", alu_bus.op_code); end
    if (ledr !== 10'h000) begin failures++; $display("FAIL rstmid_ledr got=%h exp=000", ledr); end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin failures++; $display("FAIL rstmid_idle got=active exp=idle"); end
    $display("reset mid-sweep: busy=%0b done=%0b sig=%h", busy, done, signature);
  endtask

  task automatic test_random_sweeps();
    int n;
    logic [9:0]  swv;
    logic [31:0] es;
    for (int it = 0; it < 3; it++) begin
      alu_mode = 2;
      salt = $urandom;
      swv = 10'($urandom);
      sw = swv;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(1000, n);
      es = exp_signature(2, swv, 0, 31, salt);
      checks += 2;
      if (n !== 129) begin failures++; $display("FAIL rand%0d_latency got=%0d exp=129", it, n); end
      if (signature !== es) begin failures++; $display("FAIL rand%0d_sig got=%h exp=%h", it, signature, es); end
      for (int op = 0; op < 32; op++) begin
        rd_sel = 5'(op);
        tick();
        checks++;
        if ({flags_o, ledr, ledg} !== led_word(exp_result(2, swv, op, salt))) begin
          failures++;
          $display("FAIL rand%0d_entry%0d got=%h exp=%h", it, op, {flags_o, ledr, ledg}, led_word(exp_result(2, swv, op, salt)));
        end
      end
      $display("random sweep %0d: sw=%h salt=%h sig=%h", it, swv, salt, signature);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [9:0]  swv;
    logic [31:0] es;
    alu_mode = 2;
    swv = 10'($urandom);
    sw = swv;
    start = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy got=%0b exp=1", busy); end
    tick();
    start = 1'b0;
    checks += 2;
    if (alu_bus.op_a !== {27'b0, swv[4:0]}) begin failures++; $display("FAIL b2b_op_a got=%h exp=%h", alu_bus.op_a, {27'b0, swv[4:0]}); end
    if (alu_bus.op_b !== {27'b0, swv[9:5]}) begin failures++; $display("FAIL b2b_op_b got=%h exp=%h", alu_bus.op_b, {27'b0, swv[9:5]}); end
    wait_done(1000, n);
    es = exp_signature(2, swv, 0, 31, salt);
    checks += 2;
    if (n !== 128) begin failures++; $display("FAIL b2b_latency got=%0d exp=128", n); end
    if (signature !== es) begin failures++; $display("FAIL b2b_sig got=%h exp=%h", signature, es); end
    $display("back to back: sw=%h sig=%h", swv, signature);
  endtask

  task automatic test_short_sweep();
    int n1, n2;
    logic [31:0] r;
    sw2 = 10'($urandom);
    r = exp_result(0, sw2, 3, 32'd0);
    start2 = 1'b1;
    tick();
    n1 = 0;
    while (done2 !== 1'b1 && n1 < 100) begin tick(); n1++; end
    checks++;
    if (n1 !== 4) begin failures++; $display("FAIL short_latency got=%0d exp=4", n1); end
    tick();
    checks += 2;
    if (done2 !== 1'b0) begin failures++; $display("FAIL short_one_done got=%0b exp=0", done2); end
    if (busy2 !== 1'b1) begin failures++; $display("FAIL short_relaunch got=%0b exp=1", busy2); end
    n2 = 1;
    while (done2 !== 1'b1 && n2 < 100) begin tick(); n2++; end
    start2 = 1'b0;
    checks++;
    if (n2 !== 5) begin failures++; $display("FAIL short_period got=%0d exp=5", n2); end
    rd_sel2 = 5'd3;
    tick();
    checks += 3;
    if (done2 !== 1'b1) begin failures++; $display("FAIL short_hold got=%0b exp=1", done2); end
    if (signature2 !== r) begin failures++; $display("FAIL short_sig got=%h exp=%h", signature2, r); end
    if ({flags2, ledr2, ledg2} !== led_word(r)) begin failures++; $display("FAIL short_entry got=%h exp=%h", {flags2, ledr2, ledg2}, led_word(r)); end
    $display("short sweep: latency=%0d period=%0d sig=%h", n1, n2, signature2);
  endtask

  initial begin
    test_reset();
    test_add_sweep();
    test_sw_change();
    test_opcode_sig();
    test_reset_mid();
    test_random_sweeps();
    test_back_to_back();
    test_short_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
